// File: rtl/section_diff_buffer_mc_pkg.sv
// Shared types and helpers for the multi-channel section peak-to-peak buffer.
// Holds the FSM state type and the index/window width helpers.
package section_diff_buffer_mc_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_SCAN,
        S_OUT
    } state_t;

    // Channel-index width: at least one bit even for a single channel.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned window_width(input int unsigned depth_bits);
        return depth_bits + 1;
    endfunction

endpackage

// File: rtl/section_diff_buffer_mc_accum.sv
// Per-channel running min/max/sample counter for the section reduction.
// section_done flags the sample that closes a section; sec_min/sec_max include that sample.
module channel_section_accum
    import section_diff_buffer_mc_pkg::*;
#(
    parameter int unsigned width        = 16,
    parameter int unsigned sample_count = 32,
    parameter int unsigned channels     = 2,
    localparam int unsigned CW          = idx_width(channels)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_upd,
    input  logic             i_reinit,
    input  logic [CW-1:0]    i_ch,
    input  logic [width-1:0] i_value,
    output logic             o_section_done,
    output logic [width-1:0] o_sec_min,
    output logic [width-1:0] o_sec_max
);

    localparam int unsigned CNTW = $clog2(sample_count);

    logic [width-1:0] r_min [channels];
    logic [width-1:0] r_max [channels];
    logic [CNTW-1:0]  r_cnt [channels];

    always_comb begin
        o_sec_min      = (i_value < r_min[i_ch]) ? i_value : r_min[i_ch];
        o_sec_max      = (i_value > r_max[i_ch]) ? i_value : r_max[i_ch];
        o_section_done = i_upd && (r_cnt[i_ch] == CNTW'(sample_count - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned c = 0; c < channels; c++) begin
                r_min[c] <= '1;
                r_max[c] <= '0;
                r_cnt[c] <= '0;
            end
        end else if (i_upd) begin
            if (i_reinit) begin
                r_min[i_ch] <= '1;
                r_max[i_ch] <= '0;
                r_cnt[i_ch] <= '0;
            end else begin
                r_min[i_ch] <= o_sec_min;
                r_max[i_ch] <= o_sec_max;
                r_cnt[i_ch] <= r_cnt[i_ch] + CNTW'(1);
            end
        end
    end

endmodule

// File: rtl/section_diff_buffer_mc.sv
// Multi-channel section min/max history with windowed peak-to-peak / peak result.
// Single-port registered-read history memory; one result per completed section.
module section_diff_buffer_mc
    import section_diff_buffer_mc_pkg::*;
#(
    parameter int unsigned width        = 16,
    parameter int unsigned sample_count = 32,
    parameter int unsigned depth_bits   = 8,
    parameter int unsigned channels     = 2,
    localparam int unsigned CW          = idx_width(channels),
    localparam int unsigned WW          = window_width(depth_bits)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [width-1:0] i_value,
    input  logic [CW-1:0]    i_channel,
    input  logic [WW-1:0]    window_len,
    input  logic             mode,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [width-1:0] o_value,
    output logic [CW-1:0]    o_channel
);

    localparam int unsigned DEPTH = 1 << depth_bits;
    localparam int unsigned NW    = depth_bits + 2;
    localparam int unsigned MAW   = $clog2(channels * DEPTH);

    state_t r_state, w_next;

    logic                   w_upd, w_done;
    logic [width-1:0]       w_sec_min, w_sec_max;
    logic [WW-1:0]          w_win_clamped, w_fill_next;
    logic [MAW-1:0]         w_addr;
    logic                   w_mem_we, w_mem_re;

    logic [CW-1:0]          r_ch;
    logic                   r_mode;
    logic [WW-1:0]          r_win;
    logic [2*width-1:0]     r_wr_data, r_rdata;
    logic [depth_bits-1:0]  r_wp   [channels];
    logic [WW-1:0]          r_fill [channels];
    logic [depth_bits-1:0]  r_rp;
    logic [NW-1:0]          r_cnt, r_n;
    logic [width-1:0]       r_wmin, r_wmax;
    logic [2*width-1:0]     r_mem  [channels * DEPTH];

    assign w_upd = i_valid && (r_state == S_IDLE) && (32'(i_channel) < channels);

    channel_section_accum #(
        .width        (width),
        .sample_count (sample_count),
        .channels     (channels)
    ) u_accum (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_upd          (w_upd),
        .i_reinit       (w_done),
        .i_ch           (i_channel),
        .i_value        (i_value),
        .o_section_done (w_done),
        .o_sec_min      (w_sec_min),
        .o_sec_max      (w_sec_max)
    );

    always_comb begin
        w_win_clamped = window_len;
        if (window_len == '0)
            w_win_clamped = WW'(1);
        else if (window_len > WW'(DEPTH))
            w_win_clamped = WW'(DEPTH);
        w_fill_next = (r_fill[r_ch] == WW'(DEPTH)) ? r_fill[r_ch] : r_fill[r_ch] + WW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        i_ready = 1'b0;
        o_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                i_ready = 1'b1;
                if (w_done) w_next = S_WRITE;
            end
            S_WRITE: w_next = S_SCAN;
            S_SCAN:  if (r_cnt == r_n + NW'(1)) w_next = S_OUT;
            S_OUT: begin
                o_valid = 1'b1;
                if (o_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_mem_we = (r_state == S_WRITE);
    assign w_mem_re = (r_state == S_SCAN) && (r_cnt < r_n);
    assign w_addr   = MAW'({r_ch, (w_mem_we ? r_wp[r_ch] : r_rp)});

    always_ff @(posedge clk) begin
        if (w_mem_we)
            r_mem[w_addr] <= r_wr_data;
        else if (w_mem_re)
            r_rdata <= r_mem[w_addr];
    end

    // Scan timeline: reads on counts 0..N-1, accumulate on 1..N, result on N+1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ch      <= '0;
            r_mode    <= 1'b0;
            r_win     <= '0;
            r_wr_data <= '0;
            r_rp      <= '0;
            r_cnt     <= '0;
            r_n       <= '0;
            r_wmin    <= '1;
            r_wmax    <= '0;
            o_value   <= '0;
            o_channel <= '0;
            for (int unsigned c = 0; c < channels; c++) begin
                r_wp[c]   <= '0;
                r_fill[c] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: if (w_done) begin
                    r_ch      <= i_channel;
                    r_mode    <= mode;
                    r_win     <= w_win_clamped;
                    r_wr_data <= {w_sec_max, w_sec_min};
                end
                S_WRITE: begin
                    r_wp[r_ch]   <= r_wp[r_ch] + depth_bits'(1);
                    r_fill[r_ch] <= w_fill_next;
                    r_n          <= NW'((w_fill_next < r_win) ? w_fill_next : r_win);
                    r_rp         <= r_wp[r_ch];
                    r_cnt        <= '0;
                    r_wmin       <= '1;
                    r_wmax       <= '0;
                end
                S_SCAN: begin
                    r_cnt <= r_cnt + NW'(1);
                    if (w_mem_re) r_rp <= r_rp - depth_bits'(1);
                    if ((r_cnt != '0) && (r_cnt <= r_n)) begin
                        if (r_rdata[width-1:0] < r_wmin) r_wmin <= r_rdata[width-1:0];
                        if (r_rdata[2*width-1:width] > r_wmax) r_wmax <= r_rdata[2*width-1:width];
                    end
                    if (r_cnt == r_n + NW'(1)) begin
                        o_value   <= r_mode ? r_wmax : r_wmax - r_wmin;
                        o_channel <= r_ch;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_section_diff_buffer_mc.sv
// Bench for section_diff_buffer_mc: directed scenarios plus randomized traffic
// checked against a queue-based section/window reference model.
module tb_section_diff_buffer_mc;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [15:0] i_value = '0;
    logic [1:0]  i_channel = '0;
    logic [3:0]  window_len = 4'd1;
    logic        mode = 1'b0;
    logic        o_valid;
    logic        o_ready = 1'b1;
    logic [15:0] o_value;
    logic [1:0]  o_channel;

    // Three channels so that index 3 is a representable out-of-range channel.
    section_diff_buffer_mc #(
        .width        (16),
        .sample_count (4),
        .depth_bits   (3),
        .channels     (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_valid    (i_valid),
        .i_ready    (i_ready),
        .i_value    (i_value),
        .i_channel  (i_channel),
        .window_len (window_len),
        .mode       (mode),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_value    (o_value),
        .o_channel  (o_channel)
    );

    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned cyc = 0;
    int unsigned last_acc = 0;
    int unsigned rise_cyc = 0;
    logic        prev_v = 1'b0;

    typedef struct {int unsigned ch; int unsigned val;} res_t;
    typedef struct {int unsigned ch; int unsigned val;} exp_t;
    res_t got_q[$];
    exp_t exp_q[$];

    int unsigned smp_q [3][$];
    int unsigned hmin_q[3][$];
    int unsigned hmax_q[3][$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        res_t r;
        if (o_valid && !prev_v) rise_cyc = cyc;
        prev_v = o_valid;
        if (reset_n && o_valid && o_ready) begin
            r.ch  = o_channel;
            r.val = o_value;
            got_q.push_back(r);
        end
    end

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            smp_q[c].delete();
            hmin_q[c].delete();
            hmax_q[c].delete();
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic model_accept(input int unsigned ch, input int unsigned val);
        int unsigned mn, mx, wl, n, sz, wmn, wmx;
        exp_t e;
        if (ch >= 3) return;
        smp_q[ch].push_back(val);
        if (smp_q[ch].size() < 4) return;
        mn = 32'hFFFF;
        mx = 0;
        for (int i = 0; i < 4; i++) begin
            if (smp_q[ch][i] < mn) mn = smp_q[ch][i];
            if (smp_q[ch][i] > mx) mx = smp_q[ch][i];
        end
        smp_q[ch].delete();
        hmin_q[ch].push_back(mn);
        hmax_q[ch].push_back(mx);
        wl = window_len;
        if (wl == 0) wl = 1;
        if (wl > 8) wl = 8;
        sz = hmin_q[ch].size();
        n = (sz < wl) ? sz : wl;
        wmn = 32'hFFFF;
        wmx = 0;
        for (int i = 0; i < int'(n); i++) begin
            if (hmin_q[ch][sz-1-i] < wmn) wmn = hmin_q[ch][sz-1-i];
            if (hmax_q[ch][sz-1-i] > wmx) wmx = hmax_q[ch][sz-1-i];
        end
        e.ch  = ch;
        e.val = mode ? wmx : wmx - wmn;
        exp_q.push_back(e);
    endtask

    task automatic send(input int unsigned ch, input int unsigned val);
        int unsigned g = 0;
        while (!i_ready && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (!i_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_stall i_ready=%0b required=1", i_ready);
            return;
        end
        i_valid   = 1'b1;
        i_channel = 2'(ch);
        i_value   = 16'(val);
        @(posedge clk); #1;
        last_acc = cyc;
        i_valid = 1'b0;
        model_accept(ch, val);
    endtask

    task automatic wait_results(input int unsigned want, output bit ok);
        int unsigned g = 0;
        while (got_q.size() < want && g < 500) begin
            @(posedge clk); #1;
            g++;
        end
        ok = (got_q.size() >= want);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        i_valid = 1'b0;
        o_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        reset_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        vectors++;
        if (i_ready !== 1'b1 || o_valid !== 1'b0 || o_value !== 16'd0 || o_channel !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_state got rdy=%0b vld=%0b val=%0d ch=%0d required 1 0 0 0",
                     i_ready, o_valid, o_value, o_channel);
        end
        reset_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_single_section();
        bit ok;
        res_t g;
        do_reset();
        window_len = 4'd1;
        mode = 1'b0;
        send(0, 10); send(0, 40); send(0, 20); send(0, 30);
        wait_results(1, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL single_timeout results=%0d required=1", got_q.size());
        end else begin
            g = got_q.pop_front();
            vectors++;
            if (g.val != 30 || g.ch != 0) begin
                miscompares++;
                $display("FAIL single_value got %0d/ch%0d required 30/ch0", g.val, g.ch);
            end
            vectors++;
            if (rise_cyc - last_acc != 4) begin
                miscompares++;
                $display("FAIL single_latency got %0d edges required 4", rise_cyc - last_acc);
            end
        end
    endtask

    task automatic test_interleave();
        bit ok;
        res_t g;
        int unsigned want_ch[2]  = '{0, 1};
        int unsigned want_val[2] = '{3, 50};
        do_reset();
        send(0, 1); send(1, 100); send(0, 2); send(1, 50);
        send(0, 3); send(1, 75); send(0, 4); send(1, 60);
        wait_results(2, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL interleave_timeout results=%0d required=2", got_q.size());
        end
        for (int i = 0; i < 2 && got_q.size() > 0; i++) begin
            g = got_q.pop_front();
            vectors++;
            if (g.val != want_val[i] || g.ch != want_ch[i]) begin
                miscompares++;
                $display("FAIL interleave_%0d got %0d/ch%0d required %0d/ch%0d",
                         i, g.val, g.ch, want_val[i], want_ch[i]);
            end
        end
    endtask

    task automatic test_window_modes();
        bit ok;
        res_t g;
        int unsigned secs[12] = '{0, 5, 1, 2, 10, 50, 30, 20, 20, 22, 21, 20};
        int unsigned want[2][3] = '{'{5, 50, 40}, '{5, 50, 50}};
        for (int m = 0; m < 2; m++) begin
            do_reset();
            window_len = 4'd2;
            mode = 1'(m);
            for (int i = 0; i < 12; i++) send(0, secs[i]);
            // Window/mode change while the last section is scanned must not matter.
            window_len = 4'd1;
            mode = ~mode;
            wait_results(3, ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL window_timeout mode=%0d results=%0d required=3", m, got_q.size());
            end
            for (int i = 0; i < 3 && got_q.size() > 0; i++) begin
                g = got_q.pop_front();
                vectors++;
                if (g.val != want[m][i]) begin
                    miscompares++;
                    $display("FAIL window_m%0d_%0d got %0d required %0d", m, i, g.val, want[m][i]);
                end
            end
        end
        mode = 1'b0;
    endtask

    task automatic test_wrap_clamp();
        bit ok;
        res_t g;
        int unsigned want;
        do_reset();
        window_len = 4'd9;
        mode = 1'b0;
        for (int unsigned k = 0; k < 10; k++) begin
            send(0, k + 50); send(0, 100 + k); send(0, k); send(0, k + 1);
        end
        wait_results(10, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL wrap_timeout results=%0d required=10", got_q.size());
        end
        for (int unsigned k = 0; k < 10 && got_q.size() > 0; k++) begin
            g = got_q.pop_front();
            want = 99 + ((k + 1 < 8) ? k + 1 : 8);
            vectors++;
            if (g.val != want) begin
                miscompares++;
                $display("FAIL wrap_sec%0d got %0d required %0d", k, g.val, want);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        res_t g;
        int unsigned w = 0;
        do_reset();
        window_len = 4'd1;
        o_ready = 1'b0;
        send(1, 5); send(1, 9); send(1, 7); send(1, 6);
        while (!o_valid && w < 50) begin @(posedge clk); #1; w++; end
        i_valid = 1'b1;
        i_channel = 2'd0;
        i_value = 16'd77;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (o_valid !== 1'b1 || i_ready !== 1'b0 || o_value !== 16'd4 || o_channel !== 2'd1) begin
                miscompares++;
                $display("FAIL hold_%0d got vld=%0b rdy=%0b val=%0d ch=%0d required 1 0 4 1",
                         i, o_valid, i_ready, o_value, o_channel);
            end
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        wait_results(1, ok);
        @(posedge clk); #1;
        vectors++;
        if (i_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_release i_ready=%0b required=1", i_ready);
        end
        got_q.delete();
        send(0, 3); send(0, 8); send(0, 4); send(0, 5);
        wait_results(1, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL hold_next_timeout results=%0d required=1", got_q.size());
        end else begin
            g = got_q.pop_front();
            vectors++;
            if (g.val != 5 || g.ch != 0) begin
                miscompares++;
                $display("FAIL hold_next got %0d/ch%0d required 5/ch0", g.val, g.ch);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        bit ok;
        res_t g;
        do_reset();
        window_len = 4'd8;
        for (int unsigned s = 0; s < 3; s++) begin
            send(0, 20 + s); send(0, 90); send(0, 40); send(0, 50);
            if (s < 2) wait_results(s + 1, ok);
        end
        repeat (2) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (o_valid !== 1'b0 || i_ready !== 1'b1 || o_value !== 16'd0) begin
            miscompares++;
            $display("FAIL scan_abort got vld=%0b rdy=%0b val=%0d required 0 1 0", o_valid, i_ready, o_value);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        repeat (10) begin @(posedge clk); #1; end
        vectors++;
        if (got_q.size() != 0 || o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL scan_no_partial results=%0d vld=%0b required 0 0", got_q.size(), o_valid);
        end
        send(0, 7); send(0, 9); send(0, 8);
        for (int i = 0; i < 5; i++) send(3, 1000 + i);
        vectors++;
        if (got_q.size() != 0 || i_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_ch3 results=%0d rdy=%0b required 0 1", got_q.size(), i_ready);
        end
        send(0, 7);
        wait_results(1, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL post_reset_timeout results=%0d required=1", got_q.size());
        end else begin
            g = got_q.pop_front();
            vectors++;
            if (g.val != 2 || g.ch != 0) begin
                miscompares++;
                $display("FAIL post_reset got %0d/ch%0d required 2/ch0", g.val, g.ch);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        res_t g;
        exp_t e;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            window_len = 4'($urandom_range(0, 15));
            mode = 1'($urandom_range(0, 1));
            send($urandom_range(0, 3), $urandom_range(0, 65535));
        end
        wait_results(exp_q.size(), ok);
        repeat (20) begin @(posedge clk); #1; end
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL random_count got %0d results required %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            vectors++;
            if (g.val != e.val || g.ch != e.ch) begin
                miscompares++;
                $display("FAIL random_result got %0d/ch%0d required %0d/ch%0d", g.val, g.ch, e.val, e.ch);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_section();
        test_interleave();
        test_window_modes();
        test_wrap_clamp();
        test_backpressure();
        test_reset_mid_scan();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
